// File: rtl/reg_seq_pkg.sv
// rtl/reg_seq_pkg.sv - shared constants for the register-file micro-sequencer
// Purpose: opcode, ALU function, temp-register and FSM state encodings used by
//          reg_microsequencer and reg_seq_step_rom.
// Ports: none (package).
package reg_seq_pkg;

  // Macro opcodes; 5..7 are illegal.
  localparam logic [2:0] OP_MOVE   = 3'd0;
  localparam logic [2:0] OP_ALU    = 3'd1;
  localparam logic [2:0] OP_SWAP   = 3'd2;
  localparam logic [2:0] OP_SHIFTN = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;

  // ALU function selects.
  localparam logic [3:0] FS_PASS = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_XOR  = 4'b1100;
  localparam logic [3:0] FS_SHL  = 4'b1101;

  // Temporary register used for SWAP/SHIFTN intermediates.
  localparam logic [3:0] TEMP_R8 = 4'd8;

  // FSM states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_CLEAR);
  endfunction

endpackage

// File: rtl/reg_seq_step_rom.sv
// rtl/reg_seq_step_rom.sv - combinational micro-step decode for one macro op
// Purpose: maps (op, step index, last-step flag, fields) to the register
//          address controls for that micro-step.
// Ports:
//   op_i, step_i, last_i          : which micro-step of which op
//   dr_i, sa_i, sb_i, fs_i        : latched instruction fields
//   td_o, ta_o, tb_o              : temp-select for dest / A / B
//   dx_o, ax_o, bx_o              : temp indices (0 unless matching t* set)
//   dr_o, sa_o, sb_o              : field values driven for this step
//   fs_o                          : ALU function for this step
module reg_seq_step_rom
  import reg_seq_pkg::*;
#(
  parameter int FIELD_W = 3,
  parameter int TEMP_W  = 4,
  parameter int CNT_W   = 4
) (
  input  logic [2:0]         op_i,
  input  logic [CNT_W:0]     step_i,
  input  logic               last_i,
  input  logic [FIELD_W-1:0] dr_i,
  input  logic [FIELD_W-1:0] sa_i,
  input  logic [FIELD_W-1:0] sb_i,
  input  logic [3:0]         fs_i,
  output logic               td_o,
  output logic               ta_o,
  output logic               tb_o,
  output logic [TEMP_W-1:0]  dx_o,
  output logic [TEMP_W-1:0]  ax_o,
  output logic [TEMP_W-1:0]  bx_o,
  output logic [FIELD_W-1:0] dr_o,
  output logic [FIELD_W-1:0] sa_o,
  output logic [FIELD_W-1:0] sb_o,
  output logic [3:0]         fs_o
);

  localparam logic [TEMP_W-1:0] R8 = TEMP_W'(TEMP_R8);

  always_comb begin
    td_o = 1'b0;
    ta_o = 1'b0;
    tb_o = 1'b0;
    dx_o = '0;
    ax_o = '0;
    bx_o = '0;
    dr_o = dr_i;
    sa_o = sa_i;
    sb_o = sb_i;
    fs_o = FS_PASS;
    unique case (op_i)
      OP_MOVE: ;
      OP_ALU:  fs_o = fs_i;
      OP_CLEAR: begin
        // x xor x = 0, so both operands come from the destination itself.
        sa_o = dr_i;
        sb_o = dr_i;
        fs_o = FS_XOR;
      end
      OP_SWAP: begin
        if (step_i == '0) begin
          td_o = 1'b1;           // R8 <- R[SA]
          dx_o = R8;
        end else if (!last_i) begin
          dr_o = sa_i;           // R[SA] <- R[SB]
          sa_o = sb_i;
        end else begin
          dr_o = sb_i;           // R[SB] <- R8
          ta_o = 1'b1;
          ax_o = R8;
        end
      end
      OP_SHIFTN: begin
        if (step_i == '0) begin
          td_o = 1'b1;           // R8 <- R[SA]
          dx_o = R8;
        end else if (last_i) begin
          ta_o = 1'b1;           // R[DR] <- R8
          ax_o = R8;
        end else begin
          td_o = 1'b1;           // R8 <- shl R8
          ta_o = 1'b1;
          dx_o = R8;
          ax_o = R8;
          fs_o = FS_SHL;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_microsequencer.sv
// rtl/reg_microsequencer.sv - multi-cycle micro-step controller for the register address path
// Purpose: accepts one macro instruction via valid/ready and emits one
//          registered set of register-select controls per micro-step.
// Ports:
//   clk, reset                    : clock, async active-high reset
//   start_valid/start_ready       : instruction handshake (ready only in IDLE)
//   op, dr_in, sa_in, sb_in       : opcode and register fields
//   fs_in, cnt_in                 : ALU function (ALU), shift count (SHIFTN)
//   dr, sa, sb                    : field values for the current step
//   td/ta/tb, dx/ax/bx            : temp selects and temp indices
//   rw, fs                        : write enable, ALU function
//   busy, done, err               : executing, sequence-finished pulse, illegal-op pulse
module reg_microsequencer
  import reg_seq_pkg::*;
#(
  parameter int FIELD_W = 3,
  parameter int TEMP_W  = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [2:0]         op,
  input  logic [FIELD_W-1:0] dr_in,
  input  logic [FIELD_W-1:0] sa_in,
  input  logic [FIELD_W-1:0] sb_in,
  input  logic [3:0]         fs_in,
  input  logic [CNT_W-1:0]   cnt_in,
  output logic [FIELD_W-1:0] dr,
  output logic [FIELD_W-1:0] sa,
  output logic [FIELD_W-1:0] sb,
  output logic               td,
  output logic               ta,
  output logic               tb,
  output logic [TEMP_W-1:0]  dx,
  output logic [TEMP_W-1:0]  ax,
  output logic [TEMP_W-1:0]  bx,
  output logic               rw,
  output logic [3:0]         fs,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Index of the final micro-step; one extra counter bit so cnt=15 reaches 16.
  function automatic logic [CNT_W:0] last_idx(input logic [2:0] o, input logic [CNT_W-1:0] c);
    case (o)
      OP_SWAP:   return (CNT_W+1)'(2);
      OP_SHIFTN: return {1'b0, c} + (CNT_W+1)'(1);
      default:   return '0;
    endcase
  endfunction

  // Sequencer state and latched instruction.
  logic [0:0]         state_q, state_d;
  logic [CNT_W:0]     step_q, step_d;
  logic [2:0]         op_q, op_d;
  logic [FIELD_W-1:0] fdr_q, fdr_d, fsa_q, fsa_d, fsb_q, fsb_d;
  logic [3:0]         ffs_q, ffs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Registered outputs.
  logic               rdy_q, rdy_d;
  logic [FIELD_W-1:0] odr_q, odr_d, osa_q, osa_d, osb_q, osb_d;
  logic               td_q, td_d, ta_q, ta_d, tb_q, tb_d;
  logic [TEMP_W-1:0]  dx_q, dx_d, ax_q, ax_d, bx_q, bx_d;
  logic               rw_q, rw_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [3:0]         fs_q, fs_d;

  // ROM is fed with the step about to be emitted so outputs land one cycle later.
  logic               in_idle;
  logic [2:0]         rom_op;
  logic [CNT_W:0]     rom_step;
  logic [CNT_W-1:0]   rom_cnt;
  logic [FIELD_W-1:0] rom_dr_i, rom_sa_i, rom_sb_i;
  logic [3:0]         rom_fs_i;
  logic               rom_last;
  logic               r_td, r_ta, r_tb;
  logic [TEMP_W-1:0]  r_dx, r_ax, r_bx;
  logic [FIELD_W-1:0] r_dr, r_sa, r_sb;
  logic [3:0]         r_fs;
  logic               accept, at_last;

  assign in_idle  = (state_q == ST_IDLE);
  assign accept   = in_idle & start_valid & rdy_q;
  assign at_last  = (step_q == last_idx(op_q, cnt_q));
  assign rom_op   = in_idle ? op     : op_q;
  assign rom_cnt  = in_idle ? cnt_in : cnt_q;
  assign rom_dr_i = in_idle ? dr_in  : fdr_q;
  assign rom_sa_i = in_idle ? sa_in  : fsa_q;
  assign rom_sb_i = in_idle ? sb_in  : fsb_q;
  assign rom_fs_i = in_idle ? fs_in  : ffs_q;
  assign rom_step = in_idle ? '0     : step_q + (CNT_W+1)'(1);
  assign rom_last = (rom_step == last_idx(rom_op, rom_cnt));

  reg_seq_step_rom #(.FIELD_W(FIELD_W), .TEMP_W(TEMP_W), .CNT_W(CNT_W)) u_rom (
    .op_i  (rom_op),
    .step_i(rom_step),
    .last_i(rom_last),
    .dr_i  (rom_dr_i),
    .sa_i  (rom_sa_i),
    .sb_i  (rom_sb_i),
    .fs_i  (rom_fs_i),
    .td_o  (r_td),
    .ta_o  (r_ta),
    .tb_o  (r_tb),
    .dx_o  (r_dx),
    .ax_o  (r_ax),
    .bx_o  (r_bx),
    .dr_o  (r_dr),
    .sa_o  (r_sa),
    .sb_o  (r_sb),
    .fs_o  (r_fs)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    fdr_d   = fdr_q;
    fsa_d   = fsa_q;
    fsb_d   = fsb_q;
    ffs_d   = ffs_q;
    cnt_d   = cnt_q;
    if (accept) begin
      op_d  = op;
      fdr_d = dr_in;
      fsa_d = sa_in;
      fsb_d = sb_in;
      ffs_d = fs_in;
      cnt_d = cnt_in;
    end
    // Idle-cycle output values; overwritten below when a step is emitted.
    rdy_d  = 1'b1;
    odr_d  = fdr_d;
    osa_d  = fsa_d;
    osb_d  = fsb_d;
    td_d   = 1'b0;
    ta_d   = 1'b0;
    tb_d   = 1'b0;
    dx_d   = '0;
    ax_d   = '0;
    bx_d   = '0;
    rw_d   = 1'b0;
    fs_d   = FS_PASS;
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (in_idle) begin
      if (accept) begin
        if (op_legal(op)) begin
          state_d = ST_EXEC;
          step_d  = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (at_last) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end else begin
      step_d = step_q + (CNT_W+1)'(1);
    end
    if (state_d == ST_EXEC) begin
      rdy_d  = 1'b0;
      busy_d = 1'b1;
      rw_d   = 1'b1;
      odr_d  = r_dr;
      osa_d  = r_sa;
      osb_d  = r_sb;
      td_d   = r_td;
      ta_d   = r_ta;
      tb_d   = r_tb;
      dx_d   = r_dx;
      ax_d   = r_ax;
      bx_d   = r_bx;
      fs_d   = r_fs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      op_q    <= '0;
      fdr_q   <= '0;
      fsa_q   <= '0;
      fsb_q   <= '0;
      ffs_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      odr_q   <= '0;
      osa_q   <= '0;
      osb_q   <= '0;
      td_q    <= 1'b0;
      ta_q    <= 1'b0;
      tb_q    <= 1'b0;
      dx_q    <= '0;
      ax_q    <= '0;
      bx_q    <= '0;
      rw_q    <= 1'b0;
      fs_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      fdr_q   <= fdr_d;
      fsa_q   <= fsa_d;
      fsb_q   <= fsb_d;
      ffs_q   <= ffs_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      odr_q   <= odr_d;
      osa_q   <= osa_d;
      osb_q   <= osb_d;
      td_q    <= td_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      dx_q    <= dx_d;
      ax_q    <= ax_d;
      bx_q    <= bx_d;
      rw_q    <= rw_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign start_ready = rdy_q;
  assign dr   = odr_q;
  assign sa   = osa_q;
  assign sb   = osb_q;
  assign td   = td_q;
  assign ta   = ta_q;
  assign tb   = tb_q;
  assign dx   = dx_q;
  assign ax   = ax_q;
  assign bx   = bx_q;
  assign rw   = rw_q;
  assign fs   = fs_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_reg_microsequencer.sv
// tb/tb_reg_microsequencer.sv - directed self-checking bench for reg_microsequencer
module tb_reg_microsequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [2:0] op = '0;
  logic [2:0] dr_in = '0, sa_in = '0, sb_in = '0;
  logic [3:0] fs_in = '0;
  logic [3:0] cnt_in = '0;
  logic [2:0] dr, sa, sb;
  logic       td, ta, tb;
  logic [3:0] dx, ax, bx;
  logic       rw;
  logic [3:0] fs;
  logic       busy, done, err;

  int compared = 0;
  int mismatched = 0;

  reg_microsequencer dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .dr_in(dr_in), .sa_in(sa_in), .sb_in(sb_in),
    .fs_in(fs_in), .cnt_in(cnt_in),
    .dr(dr), .sa(sa), .sb(sb),
    .td(td), .ta(ta), .tb(tb),
    .dx(dx), .ax(ax), .bx(bx),
    .rw(rw), .fs(fs), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [3:0] f, input logic [3:0] c);
    op = o; dr_in = d; sa_in = a; sb_in = b; fs_in = f; cnt_in = c;
    start_valid = 1'b1;
  endtask

  // Counts rw cycles until done, bounded; called on the first step cycle.
  task automatic count_steps(output int n, output bit saw_done);
    n = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (rw) n++;
      if (busy && done) n = 1000;
      tick();
    end
  endtask

  int  nsteps;
  bit  got_done;

  initial begin
    // Reset state
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_ready", start_ready, 1);
    chk("rst_rw",    rw, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);

    // MOVE dr=3 sa=5
    offer(3'd0, 3'd3, 3'd5, 3'd0, 4'hF, 4'd0);
    tick();
    start_valid = 1'b0;
    chk("mov_rw", rw, 1);
    chk("mov_dr", dr, 3);
    chk("mov_sa", sa, 5);
    chk("mov_tdta", {td, ta}, 0);
    chk("mov_fs", fs, 4'b0000);
    chk("mov_ready", start_ready, 0);
    tick();
    chk("mov_done", done, 1);
    chk("mov_busy", busy, 0);
    chk("mov_rw_off", rw, 0);
    tick();
    chk("mov_done_pulse", done, 0);

    // SWAP sa=1 sb=2
    offer(3'd2, 3'd0, 3'd1, 3'd2, 4'h0, 4'd0);
    tick();
    start_valid = 1'b0;
    chk("swp0_rw", rw, 1);
    chk("swp0_td_dx", {td, dx}, {1'b1, 4'd8});
    chk("swp0_sa", sa, 1);
    chk("swp0_ta", ta, 0);
    tick();
    chk("swp1_rw", rw, 1);
    chk("swp1_dest", dr, 1);
    chk("swp1_a", sa, 2);
    chk("swp1_tdta", {td, ta}, 0);
    tick();
    chk("swp2_rw", rw, 1);
    chk("swp2_dest", dr, 2);
    chk("swp2_ta_ax", {ta, ax}, {1'b1, 4'd8});
    chk("swp2_td", td, 0);
    chk("swp2_fs", fs, 0);
    tick();
    chk("swp_done", done, 1);
    chk("swp_rw_off", rw, 0);
    tick();

    // SHIFTN sa=4 dr=6 cnt=3
    offer(3'd3, 3'd6, 3'd4, 3'd0, 4'h0, 4'd3);
    tick();
    start_valid = 1'b0;
    chk("shn0_td_dx", {td, ta, dx}, {1'b1, 1'b0, 4'd8});
    chk("shn0_sa", sa, 4);
    chk("shn0_fs", fs, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("shn%0d_sel", i), {rw, td, ta, dx, ax}, {3'b111, 4'd8, 4'd8});
      chk($sformatf("shn%0d_fs", i), fs, 4'b1101);
    end
    tick();
    chk("shn4_ta_ax", {rw, td, ta, ax}, {3'b101, 4'd8});
    chk("shn4_dx", dx, 0);
    chk("shn4_dr", dr, 6);
    chk("shn4_fs", fs, 0);
    tick();
    chk("shn_done", done, 1);
    tick();

    // SHIFTN cnt=0 -> 2 steps
    offer(3'd3, 3'd1, 3'd2, 3'd0, 4'h0, 4'd0);
    tick();
    start_valid = 1'b0;
    count_steps(nsteps, got_done);
    chk("shn_c0_steps", nsteps, 2);
    chk("shn_c0_done", got_done, 1);
    tick();

    // SHIFTN cnt=15 -> 17 steps
    offer(3'd3, 3'd1, 3'd2, 3'd0, 4'h0, 4'd15);
    tick();
    start_valid = 1'b0;
    count_steps(nsteps, got_done);
    chk("shn_c15_steps", nsteps, 17);
    chk("shn_c15_done", got_done, 1);
    tick();

    // Illegal op=6
    offer(3'd6, 3'd1, 3'd1, 3'd1, 4'h0, 4'd0);
    tick();
    start_valid = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_rw", rw, 0);
    chk("ill_done", done, 0);
    chk("ill_ready", start_ready, 1);
    chk("ill_busy", busy, 0);
    tick();
    chk("ill_err_pulse", err, 0);
    chk("ill_rw2", rw, 0);

    // Back-to-back: ALU then CLEAR held on start_valid
    offer(3'd1, 3'd2, 3'd3, 3'd4, 4'b0010, 4'd0);
    tick();
    chk("alu_rw", rw, 1);
    chk("alu_fs", fs, 4'b0010);
    chk("alu_fields", {dr, sa, sb}, {3'd2, 3'd3, 3'd4});
    offer(3'd4, 3'd7, 3'd1, 3'd5, 4'h0, 4'd0);
    tick();
    chk("b2b_done", {done, start_ready, busy}, 3'b110);
    tick();
    start_valid = 1'b0;
    chk("clr_rw_busy", {rw, busy, done}, 3'b110);
    chk("clr_fields", {dr, sa, sb}, {3'd7, 3'd7, 3'd7});
    chk("clr_fs", fs, 4'b1100);
    tick();
    chk("clr_done", done, 1);
    tick();

    // SWAP with reset asserted during its second step
    offer(3'd2, 3'd0, 3'd3, 3'd3, 4'h0, 4'd0);
    tick();
    start_valid = 1'b0;
    tick();
    chk("rsw_rw_before", rw, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rsw_rw", rw, 0);
    chk("rsw_busy", busy, 0);
    tick();
    chk("rsw_rw_held", rw, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rsw_ready", start_ready, 1);
    chk("rsw_idle", {rw, busy, done, err}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
